// File: rtl/mac_lookup_arbiter_pkg.sv
// Shared types for the MAC lookup path: VLAN/MAC types, port widths and the per-card request record.
package mac_lookup_arbiter_pkg;

    typedef logic [11:0] vlan_t;
    typedef logic [47:0] macaddr_t;

    localparam int unsigned LOOKUP_PORT_WIDTH = 6;
    localparam int unsigned LOCAL_PORT_WIDTH  = 5;

    typedef struct packed {
        vlan_t                       src_vlan;
        macaddr_t                    src_mac;
        logic [LOCAL_PORT_WIDTH-1:0] src_port;
        macaddr_t                    dst_mac;
    } lookup_req_t;

endpackage

// File: rtl/mac_lookup_arbiter_if.sv
// Lookup port of the MAC address table: strobe plus key fields out, in-order result back.
interface mac_lookup_arbiter_if;
    import mac_lookup_arbiter_pkg::*;

    logic                         lookup_en;
    vlan_t                        lookup_src_vlan;
    macaddr_t                     lookup_src_mac;
    logic [LOOKUP_PORT_WIDTH-1:0] lookup_src_port;
    macaddr_t                     lookup_dst_mac;
    logic                         lookup_done;
    logic                         lookup_hit;
    logic [LOOKUP_PORT_WIDTH-1:0] lookup_dst_port;

    modport master (
        output lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
        input  lookup_done, lookup_hit, lookup_dst_port
    );

    modport slave (
        input  lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
        output lookup_done, lookup_hit, lookup_dst_port
    );

endinterface

// File: rtl/mac_lookup_tag_fifo.sv
// Synchronous tag FIFO holding the issuing card index of each in-flight lookup.
module mac_lookup_tag_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Round-robin sharing of the MAC table lookup port between line cards, with in-order result routing.
module mac_lookup_arbiter
    import mac_lookup_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned PORTS_PER_CARD  = 24,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_en,
    input  logic [12*NUM_REQ-1:0]                 req_src_vlan,
    input  logic [48*NUM_REQ-1:0]                 req_src_mac,
    input  logic [LOCAL_PORT_WIDTH*NUM_REQ-1:0]   req_src_port,
    input  logic [48*NUM_REQ-1:0]                 req_dst_mac,
    output logic [NUM_REQ-1:0]                    resp_done,
    output logic                                  resp_hit,
    output logic [LOOKUP_PORT_WIDTH-1:0]          resp_dst_port,
    mac_lookup_arbiter_if.master                  tbl,
    output logic                                  proto_err
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    lookup_req_t        req_in [NUM_REQ];
    lookup_req_t        hold   [NUM_REQ];
    lookup_req_t        gnt_req;
    logic [NUM_REQ-1:0] pending, outstanding, accept, eligible;
    logic [NUM_REQ-1:0] gnt_onehot, pop_onehot;
    logic [IDX_W-1:0]   rr, gnt_idx, cand, head;
    logic               gnt_vld, can_grant, pop_ok;
    logic               fifo_full, fifo_empty;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_in[i].src_vlan = req_src_vlan[i*12 +: 12];
            req_in[i].src_mac  = req_src_mac[i*48 +: 48];
            req_in[i].src_port = req_src_port[i*LOCAL_PORT_WIDTH +: LOCAL_PORT_WIDTH];
            req_in[i].dst_mac  = req_dst_mac[i*48 +: 48];
        end
    end

    // A card may have only one request in the system: either waiting here or in the table.
    assign accept    = req_en & ~pending & ~outstanding;
    assign eligible  = pending | accept;
    assign pop_ok    = tbl.lookup_done && !fifo_empty;
    assign can_grant = !fifo_full || pop_ok;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (32'(rr) + k >= NUM_REQ) cand = IDX_W'(32'(rr) + k - NUM_REQ);
            else                        cand = IDX_W'(32'(rr) + k);
            if (!gnt_vld && can_grant && eligible[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_req    = pending[gnt_idx] ? hold[gnt_idx] : req_in[gnt_idx];
        gnt_onehot = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
        pop_onehot = pop_ok  ? (NUM_REQ'(1) << head)    : '0;
    end

    mac_lookup_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (gnt_vld),
        .push_data (gnt_idx),
        .pop       (tbl.lookup_done),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) hold[i] <= req_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending             <= '0;
            outstanding         <= '0;
            rr                  <= '0;
            tbl.lookup_en       <= 1'b0;
            tbl.lookup_src_vlan <= '0;
            tbl.lookup_src_mac  <= '0;
            tbl.lookup_src_port <= '0;
            tbl.lookup_dst_mac  <= '0;
            resp_done           <= '0;
            resp_hit            <= 1'b0;
            resp_dst_port       <= '0;
            proto_err           <= 1'b0;
        end else begin
            pending       <= eligible & ~gnt_onehot;
            outstanding   <= (outstanding | gnt_onehot) & ~pop_onehot;
            tbl.lookup_en <= gnt_vld;
            resp_done     <= pop_onehot;
            if (gnt_vld) begin
                rr                  <= (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                tbl.lookup_src_vlan <= gnt_req.src_vlan;
                tbl.lookup_src_mac  <= gnt_req.src_mac;
                tbl.lookup_src_port <= LOOKUP_PORT_WIDTH'(32'(gnt_idx) * PORTS_PER_CARD + 32'(gnt_req.src_port));
                tbl.lookup_dst_mac  <= gnt_req.dst_mac;
            end
            if (pop_ok) begin
                resp_hit      <= tbl.lookup_hit;
                resp_dst_port <= tbl.lookup_dst_port;
            end
            if (|(req_en & (pending | outstanding)) || (tbl.lookup_done && fifo_empty))
                proto_err <= 1'b1;
        end
    end

endmodule
